// File: rtl/uart_packet_rx.sv
// UART receiver that assembles MSG_WIDTH/DATA_WIDTH words into one packet (header in MSBs, payload in LSBs).
// Latency: packet visible on msg_valid 1 clk after the last stop-bit sample.
// Backpressure: a packet is held while msg_valid & ~msg_ready; a packet completing then is dropped with overrun_err.
// Ports: clk, rst (sync, active-high), uart_rx_pin (async serial, idle high),
//        msg_header/msg_payload/msg_valid/msg_ready (packet handshake),
//        frame_err/timeout_err/overrun_err (one-cycle error pulses).
module uart_packet_rx #(
    parameter int CLKS_PER_BAUD = 1250,
    parameter int DATA_WIDTH    = 8,
    parameter int STOP_BITS     = 1,
    parameter int MSG_WIDTH     = 64,
    parameter int HEADER_WIDTH  = 8,
    parameter int TIMEOUT_CLKS  = 24000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              uart_rx_pin,
    output logic [HEADER_WIDTH-1:0]           msg_header,
    output logic [MSG_WIDTH-HEADER_WIDTH-1:0] msg_payload,
    output logic                              msg_valid,
    input  logic                              msg_ready,
    output logic                              frame_err,
    output logic                              timeout_err,
    output logic                              overrun_err
);

    localparam int CW     = $clog2(CLKS_PER_BAUD);
    localparam int NWORDS = MSG_WIDTH / DATA_WIDTH;
    localparam int KW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int BW     = $clog2(DATA_WIDTH + 1);
    localparam int SW     = $clog2(STOP_BITS + 1);
    localparam int GW     = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BAUD / 2 - 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BAUD - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);
    localparam logic [KW-1:0] K_LAST    = KW'(NWORDS - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // ---------------- synchronizer and start-edge detect ----------------
    logic       sync1, sync2, line_q;
    logic [1:0] flush;
    logic       armed;
    logic       fall;

    // The sync stages reset high, so their output is meaningless until two
    // real samples have flushed through. 'armed' waits for a genuine high on
    // the line so a line held low across reset release is not a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            line_q <= 1'b1;
            flush  <= 2'b00;
            armed  <= 1'b0;
        end else begin
            sync1  <= uart_rx_pin;
            sync2  <= sync1;
            line_q <= sync2;
            flush  <= {flush[0], 1'b1};
            if (flush[1] && sync2)
                armed <= 1'b1;
        end
    end

    assign fall = armed & line_q & ~sync2;

    // ---------------- bit FSM ----------------
    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [BW-1:0]         bit_idx, bit_n;
    logic [SW-1:0]         stop_idx, stop_n;
    logic                  stop_bad, stop_bad_n;
    logic [DATA_WIDTH-1:0] shreg, shreg_n;
    logic                  word_stb;
    logic                  frame_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= '0;
            stop_bad <= 1'b0;
            shreg    <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_n;
            stop_idx <= stop_n;
            stop_bad <= stop_bad_n;
            shreg    <= shreg_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt + CW'(1);
        bit_n      = bit_idx;
        stop_n     = stop_idx;
        stop_bad_n = stop_bad;
        shreg_n    = shreg;
        word_stb   = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (fall)
                    state_n = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    // A high line at mid start bit was a glitch: drop quietly.
                    if (!sync2) begin
                        state_n = DATA;
                        bit_n   = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == BAUD_LAST) begin
                    cnt_n   = '0;
                    shreg_n = (shreg >> 1) | (DATA_WIDTH'(sync2) << (DATA_WIDTH - 1));
                    if (bit_idx == DATA_LAST) begin
                        state_n    = STOP;
                        stop_n     = '0;
                        stop_bad_n = 1'b0;
                    end else begin
                        bit_n = bit_idx + BW'(1);
                    end
                end
            end
            STOP: begin
                if (cnt == BAUD_LAST) begin
                    cnt_n      = '0;
                    stop_bad_n = stop_bad | ~sync2;
                    // Leave at mid stop bit so a back-to-back start edge is seen.
                    if (stop_idx == STOP_LAST) begin
                        state_n = IDLE;
                        if (stop_bad || !sync2)
                            frame_bad = 1'b1;
                        else
                            word_stb = 1'b1;
                    end else begin
                        stop_n = stop_idx + SW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // ---------------- packet assembler ----------------
    logic [KW-1:0]        k;
    logic [GW-1:0]        gap;
    logic                 gap_hit;
    logic                 last_stb;
    logic [MSG_WIDTH-1:0] msg_buf;
    logic [MSG_WIDTH-1:0] asm_msg;

    assign gap_hit  = (k != '0) && (gap == GAP_LAST) && !word_stb;
    assign last_stb = word_stb && (k == K_LAST);

    // Full packet as it would look with the word arriving this cycle merged in.
    always_comb begin
        asm_msg = msg_buf;
        asm_msg[int'(k) * DATA_WIDTH +: DATA_WIDTH] = shreg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k           <= '0;
            gap         <= '0;
            msg_buf     <= '0;
            msg_header  <= '0;
            msg_payload <= '0;
            msg_valid   <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= frame_bad;
            timeout_err <= gap_hit;
            overrun_err <= last_stb && msg_valid && !msg_ready;

            if (word_stb || gap_hit || k == '0)
                gap <= '0;
            else
                gap <= gap + GW'(1);

            // Frame error and timeout together clear the assembler once.
            if (frame_bad || gap_hit)
                k <= '0;
            else if (word_stb)
                k <= (k == K_LAST) ? '0 : k + KW'(1);

            if (word_stb)
                msg_buf <= asm_msg;

            if (last_stb && (!msg_valid || msg_ready)) begin
                msg_header  <= asm_msg[MSG_WIDTH-1 -: HEADER_WIDTH];
                msg_payload <= asm_msg[MSG_WIDTH-HEADER_WIDTH-1:0];
                msg_valid   <= 1'b1;
            end else if (msg_valid && msg_ready) begin
                msg_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_packet_rx.sv
// Self-checking bench for uart_packet_rx with a short baud (16 clk) and timeout (400 clk).
// Drives the serial line from directed packets; a sampling monitor counts output events.
// Checks: reset state, packet decode, glitch rejection, frame error, timeout, overrun/hold, reset mid-word.
module tb_uart_packet_rx;

    localparam int CPB = 16;
    localparam int TO  = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_rx_pin;
    logic [7:0]  msg_header;
    logic [55:0] msg_payload;
    logic        msg_valid;
    logic        msg_ready;
    logic        frame_err;
    logic        timeout_err;
    logic        overrun_err;

    uart_packet_rx #(
        .CLKS_PER_BAUD(CPB),
        .DATA_WIDTH   (8),
        .STOP_BITS    (1),
        .MSG_WIDTH    (64),
        .HEADER_WIDTH (8),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx_pin(uart_rx_pin),
        .msg_header (msg_header),
        .msg_payload(msg_payload),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .frame_err  (frame_err),
        .timeout_err(timeout_err),
        .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- monitor (samples 1 time unit after each rising edge) ----------------
    int          n_valid = 0, n_vhigh = 0, n_frame = 0, n_timeout = 0, n_overrun = 0, n_unstable = 0;
    logic [7:0]  cap_hdr = '0;
    logic [55:0] cap_pay = '0;
    logic        valid_q = 1'b0;
    logic [7:0]  hdr_q = '0;
    logic [55:0] pay_q = '0;

    always @(posedge clk) begin
        #1;
        if (msg_valid && !valid_q) begin
            n_valid++;
            cap_hdr = msg_header;
            cap_pay = msg_payload;
        end
        if (msg_valid) n_vhigh++;
        if (valid_q && !msg_ready && (msg_header !== hdr_q || msg_payload !== pay_q))
            n_unstable++;
        if (frame_err)   n_frame++;
        if (timeout_err) n_timeout++;
        if (overrun_err) n_overrun++;
        valid_q = msg_valid;
        hdr_q   = msg_header;
        pay_q   = msg_payload;
    end

    // ---------------- serial stimulus ----------------
    task automatic send_word(input logic [7:0] d, input logic stop_ok);
        uart_rx_pin = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx_pin = d[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx_pin = stop_ok;
        repeat (CPB) @(negedge clk);
        uart_rx_pin = 1'b1;
        if (!stop_ok) repeat (CPB) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic send_words(input logic [63:0] m, input int first, input int count);
        for (int w = first; w < first + count; w++)
            send_word(m[w*8 +: 8], 1'b1);
    endtask

    task automatic check_pkt(input string tag, input int exp_n, input logic [63:0] m);
        chk({tag, "_count"},   64'(n_valid), 64'(exp_n));
        chk({tag, "_header"},  64'(cap_hdr), 64'(m[63:56]));
        chk({tag, "_payload"}, 64'(cap_pay), 64'(m[55:0]));
    endtask

    // Words sent LSB first: 00,00,10,00,49,51,00,03
    localparam logic [63:0] P1 = 64'h0300_5149_0010_0000;
    localparam logic [63:0] P2 = 64'hA55A_0123_4567_89EF;
    localparam logic [63:0] P3 = 64'h7E81_FF00_C3_3C_AA_55;
    localparam logic [63:0] P4 = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] P5 = 64'hC0FF_EE00_DEAD_BEEF;
    localparam logic [63:0] P6 = 64'h0F1E_2D3C_4B5A_6978;
    localparam logic [63:0] P7 = 64'hFFFF_FFFF_1122_3344;
    localparam logic [63:0] P8 = 64'h8001_0203_0405_0607;

    initial begin
        uart_rx_pin = 1'b1;
        msg_ready   = 1'b1;
        rst         = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_valid",   64'(msg_valid),   64'd0);
        chk("rst_header",  64'(msg_header),  64'd0);
        chk("rst_payload", 64'(msg_payload), 64'd0);
        chk("rst_frame",   64'(frame_err),   64'd0);
        chk("rst_timeout", 64'(timeout_err), 64'd0);
        chk("rst_overrun", 64'(overrun_err), 64'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Basic packet with consumer always ready: exactly one valid cycle.
        send_words(P1, 0, 8);
        repeat (5) @(negedge clk);
        check_pkt("p1", 1, P1);
        chk("p1_valid_cycles", 64'(n_vhigh), 64'd1);
        chk("p1_valid_low",    64'(msg_valid), 64'd0);

        // Short low glitch on idle line: ignored.
        uart_rx_pin = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx_pin = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk("glitch_frame", 64'(n_frame), 64'd0);
        chk("glitch_valid", 64'(n_valid), 64'd1);
        send_words(P2, 0, 8);
        repeat (5) @(negedge clk);
        check_pkt("p2", 2, P2);

        // Stop bit low on word index 3 discards the partial packet.
        send_words(P3, 0, 3);
        send_word(P3[31:24], 1'b0);
        repeat (5) @(negedge clk);
        chk("frame_count", 64'(n_frame), 64'd1);
        chk("frame_novalid", 64'(n_valid), 64'd2);
        send_words(P3, 0, 8);
        repeat (5) @(negedge clk);
        check_pkt("p3", 3, P3);
        chk("frame_once", 64'(n_frame), 64'd1);

        // Three words then a long gap.
        send_words(P4, 0, 3);
        repeat (100) @(negedge clk);
        chk("timeout_early", 64'(n_timeout), 64'd0);
        repeat (TO) @(negedge clk);
        chk("timeout_count", 64'(n_timeout), 64'd1);
        send_words(P4, 0, 8);
        repeat (5) @(negedge clk);
        check_pkt("p4", 4, P4);
        chk("timeout_once", 64'(n_timeout), 64'd1);

        // Consumer stalls: first packet held, second dropped.
        msg_ready = 1'b0;
        send_words(P5, 0, 8);
        repeat (5) @(negedge clk);
        check_pkt("p5", 5, P5);
        send_words(P6, 0, 8);
        repeat (5) @(negedge clk);
        chk("ovr_count",   64'(n_overrun),   64'd1);
        chk("ovr_header",  64'(msg_header),  64'(P5[63:56]));
        chk("ovr_payload", 64'(msg_payload), 64'(P5[55:0]));
        chk("ovr_stable",  64'(n_unstable),  64'd0);
        chk("ovr_held",    64'(msg_valid),   64'd1);
        msg_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ovr_release", 64'(msg_valid), 64'd0);
        chk("ovr_nvalid",  64'(n_valid),   64'd5);
        @(negedge clk);

        // Reset during word index 4 (all-zero data), released while the line is low.
        send_words(P7, 0, 4);
        fork
            send_word(8'h00, 1'b1);
            begin
                repeat (2 * CPB) @(negedge clk);
                rst = 1'b1;
                repeat (3 * CPB) @(negedge clk);
                rst = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        chk("rst_mid_valid", 64'(n_valid), 64'd5);
        chk("rst_mid_frame", 64'(n_frame), 64'd1);
        send_words(P8, 0, 8);
        repeat (5) @(negedge clk);
        check_pkt("p8", 6, P8);
        chk("final_frame",   64'(n_frame),   64'd1);
        chk("final_timeout", 64'(n_timeout), 64'd1);
        chk("final_overrun", 64'(n_overrun), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
